cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor. It extends the fixed 16-bit lookahead adder to a configurable WIDTH, split into CHUNK-bit lookahead slices with one register stage per slice. It adds a subtract mode, signed-overflow and zero flags, and valid/ready handshakes on both sides. It sits between operand-issue logic and result consumers in the datapath, sustaining one operation per cycle.

## Interface
- WIDTH, 32, operand/result width; multiple of CHUNK, 8..64.
- CHUNK, 16, bits resolved per pipeline stage; multiple of 4, built from 4-bit lookahead groups with group G/P.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts the operand set this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- c_in  input  1  carry-in; used only when sub=0.
- sub  input  1  0: x+y+c_in; 1: x-y (x + ~y + 1, c_in ignored).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result this cycle.
- s  output  WIDTH  sum/difference.
- c_out  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  s == 0.

## Operation
- NS = WIDTH/CHUNK stages. Stage k (0..NS-1) computes result bits [k*CHUNK +: CHUNK] from the operand slice and the carry registered by stage k-1. Stage 0 uses c_in, or 1 when sub=1.
- Operand B is inverted at acceptance when sub=1. Not-yet-used upper operand slices are skewed (carried forward) through the stage registers. Completed lower result slices are carried forward to the last stage.
- Inside a stage, carries come from 4-bit group G/P lookahead, not a ripple across CHUNK. The intra-chunk carry path spans at most CHUNK/4 group levels.
- Each stage holds a valid bit. Advance condition is adv = !out_valid | out_ready. When adv=1, every stage loads from its predecessor, and stage 0 loads {in_valid, operands}. When adv=0, all stages hold.
- in_ready = adv (combinational from out_valid and out_ready). A transfer occurs when in_valid & in_ready.
- Output registers s, c_out, ovf, zero are the last stage's registers. They are held stable while out_valid=1 and out_ready=0.
- ovf and zero are computed in the last stage from the final slice and its carries. They are meaningful for both modes.
- Bubbles: a stage whose valid bit is 0 still shifts, so gaps collapse only at the output.
- Results emerge strictly in acceptance order. No operation is dropped or duplicated.

## Timing
- Reset: all stage valid bits = 0, out_valid = 0, s = 0, c_out = 0, ovf = 0, zero = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded. No out_valid is asserted for them.
- Latency: an operand accepted at edge T yields out_valid=1 after edge T+NS-1, i.e. NS cycles. The default configuration has a latency of 2 cycles.
- Throughput: 1 result/cycle while out_ready=1.
- Backpressure: when out_valid=1 and out_ready=0, the whole pipe stalls and in_ready=0 in the same cycle.
- When out_ready and in_valid are both high with a full pipe, the pipe accepts and emits in the same cycle with no bubble.
- CHUNK=WIDTH (NS=1) is legal: single register stage, latency 1.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, s=0, flags 0 throughout. in_ready=1 after release.
- Add wrap: x=0xFFFF_FFFF, y=0x0000_0001, c_in=0, sub=0 -> 2 cycles later s=0x0000_0000, c_out=1, zero=1, ovf=0.
- Chunk-boundary carry: x=0x0000_FFFF, y=0x0000_0000, c_in=1 -> s=0x0001_0000, c_out=0, zero=0.
- Subtract overflow: x=0x8000_0000, y=0x0000_0001, sub=1 -> s=0x7FFF_FFFF, c_out=1, ovf=1. Then x=5, y=7, sub=1 -> s=0xFFFF_FFFE, c_out=0, ovf=0.
- Backpressure: issue 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) and drop out_ready for 3 cycles after the first result. Required: in_ready=0 during the stall, s held stable, results 2, 4, 6, 8 in order, none lost.
- Reset flush: accept 2 operations, assert reset the next cycle -> no out_valid for either. The next operation after release appears with normal 2-cycle latency.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// Each stage resolves one CHUNK-bit slice using 4-bit group generate/propagate lookahead.
// Unused upper operand slices and finished lower result slices travel down the pipe.
// The last stage's registers drive the result and flag outputs directly.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NS = WIDTH / CHUNK;
    localparam int unsigned NG = CHUNK / 4;

    // Returns {carry into slice MSB, carry out of slice, slice sum}.
    function automatic logic [CHUNK+1:0] cla_slice(input logic [CHUNK-1:0] a,
                                                   input logic [CHUNK-1:0] b,
                                                   input logic             ci);
        logic [CHUNK-1:0] g, p, c;
        logic             gc, gg, gp;
        int unsigned      base;
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gc = ci;
        for (int unsigned i = 0; i < NG; i++) begin
            base = 4 * i;
            c[base]   = gc;
            c[base+1] = g[base] | (p[base] & gc);
            c[base+2] = g[base+1] | (p[base+1] & g[base]) | (p[base+1] & p[base] & gc);
            c[base+3] = g[base+2] | (p[base+2] & g[base+1])
                      | (p[base+2] & p[base+1] & g[base])
                      | (p[base+2] & p[base+1] & p[base] & gc);
            gg = g[base+3] | (p[base+3] & g[base+2])
               | (p[base+3] & p[base+2] & g[base+1])
               | (p[base+3] & p[base+2] & p[base+1] & g[base]);
            gp = p[base+3] & p[base+2] & p[base+1] & p[base];
            gc = gg | (gp & gc);
        end
        return {c[CHUNK-1], gc, p ^ c};
    endfunction

    logic [WIDTH-1:0] a_q   [NS];
    logic [WIDTH-1:0] b_q   [NS];
    logic [WIDTH-1:0] r_q   [NS];
    logic [NS-1:0]    v_q;
    logic [NS-1:0]    cy_q;
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] a_src [NS];
    logic [WIDTH-1:0] b_src [NS];
    logic [WIDTH-1:0] r_src [NS];
    logic [NS-1:0]    c_src;
    logic [NS-1:0]    v_src;

    logic [WIDTH-1:0] r_d   [NS];
    logic [NS-1:0]    cy_d;
    logic             ovf_d;
    logic             zero_d;
    logic             adv;

    assign out_valid = v_q[NS-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign s         = r_q[NS-1];
    assign c_out     = cy_q[NS-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Stage inputs: stage 0 takes the issue port (B inverted for subtract), later stages their predecessor.
    always_comb begin
        a_src[0] = x;
        b_src[0] = sub ? ~y : y;
        r_src[0] = '0;
        c_src    = '0;
        v_src    = '0;
        c_src[0] = sub ? 1'b1 : c_in;
        v_src[0] = in_valid;
        for (int unsigned k = 1; k < NS; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            r_src[k] = r_q[k-1];
            c_src[k] = cy_q[k-1];
            v_src[k] = v_q[k-1];
        end
    end

    // Per-stage slice lookahead; flags come from the final slice.
    always_comb begin
        logic [CHUNK+1:0] sl;
        sl     = '0;
        cy_d   = '0;
        ovf_d  = 1'b0;
        for (int unsigned k = 0; k < NS; k++) begin
            sl = cla_slice(a_src[k][k*CHUNK +: CHUNK], b_src[k][k*CHUNK +: CHUNK], c_src[k]);
            r_d[k] = r_src[k];
            r_d[k][k*CHUNK +: CHUNK] = sl[CHUNK-1:0];
            cy_d[k] = sl[CHUNK];
            if (k == NS - 1) begin
                ovf_d = sl[CHUNK+1] ^ sl[CHUNK];
            end
        end
        zero_d = (r_d[NS-1] == '0);
    end

    // Stage registers: whole pipe shifts together on advance, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            cy_q   <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < NS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (adv) begin
            v_q    <= v_src;
            cy_q   <= cy_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int unsigned k = 0; k < NS; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                r_q[k] <= r_d[k];
            end
        end
    end

endmodule
